// File: rtl/icache_fill_ctrl.sv
// Miss/refill sequencer between L1 and L2 instruction caches and the external bus.
// Probes L2 on an L1 miss, refills L2 from two bus beats when needed, then loads L1.
module icache_fill_ctrl #(
  parameter int AMSB     = 79,
  parameter int pTimeout = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            miss_i,
  input  logic [AMSB:0]   miss_adr_i,
  input  logic            exv_i,
  input  logic            inv_i,
  output logic            busy_o,
  output logic [AMSB:0]   l2_adr_o,
  output logic            l2_wr_o,
  output logic [2:0]      l2_cnt_o,
  output logic [127:0]    l2_dat_o,
  output logic            l2_exv_o,
  output logic            l2_err_o,
  input  logic            l2_hit_i,
  input  logic [257:0]    l2_dat_i,
  output logic            l1_wr_o,
  output logic [AMSB:0]   l1_wadr_o,
  output logic [257:0]    l1_dat_o,
  output logic            nxt_o,
  output logic            cyc_o,
  output logic            stb_o,
  output logic [AMSB:0]   adr_o,
  input  logic [127:0]    dat_i,
  input  logic            ack_i,
  input  logic            err_i
);

  typedef enum logic [2:0] {
    IDLE, L2RD, L2CHK, BUS0, BUS1, SETTLE, L1WR, DONE
  } state_t;

  localparam logic [7:0]    TMO_MAX = 8'(pTimeout);
  localparam logic [AMSB:0] BEAT1   = {{(AMSB-4){1'b0}}, 5'b10000};

  state_t         state_q, state_d;
  logic [AMSB:0]  ladr_q, ladr_d;
  logic           exv_q, exv_d;
  logic           inv_q, inv_d;
  logic [7:0]     tmo_q, tmo_d;
  logic [257:0]   l1_dat_q, l1_dat_d;
  logic           bus_err;
  logic           beat_end;

  always_comb begin
    state_d   = state_q;
    ladr_d    = ladr_q;
    exv_d     = exv_q;
    inv_d     = inv_q | (inv_i & (state_q != IDLE));
    tmo_d     = 8'd0;
    l1_dat_d  = l1_dat_q;
    l2_wr_o   = 1'b0;
    l2_cnt_o  = 3'd0;
    l2_dat_o  = '0;
    l2_exv_o  = 1'b0;
    l2_err_o  = 1'b0;
    l1_wr_o   = 1'b0;
    l1_wadr_o = '0;
    nxt_o     = 1'b0;
    cyc_o     = 1'b0;
    stb_o     = 1'b0;
    adr_o     = '0;
    l2_adr_o  = '0;
    busy_o    = (state_q != IDLE);
    bus_err   = err_i | (tmo_q == TMO_MAX);
    beat_end  = ack_i | bus_err;

    if (state_q != IDLE)
      l2_adr_o = (state_q == BUS1) ? (ladr_q | BEAT1) : ladr_q;

    case (state_q)
      IDLE: begin
        if (miss_i) begin
          ladr_d  = {miss_adr_i[AMSB:5], 5'b0};
          exv_d   = exv_i;
          inv_d   = 1'b0;
          state_d = L2RD;
        end
      end
      L2RD: state_d = L2CHK;
      L2CHK: begin
        if (l2_hit_i) begin
          l1_dat_d = l2_dat_i;
          state_d  = L1WR;
        end else begin
          state_d  = BUS0;
        end
      end
      BUS0, BUS1: begin
        cyc_o = 1'b1;
        stb_o = 1'b1;
        adr_o = (state_q == BUS1) ? (ladr_q | BEAT1) : ladr_q;
        l2_cnt_o = {2'b00, state_q == BUS1};
        // timeout counter restarts at every beat start, saturating otherwise
        if (beat_end) begin
          l2_wr_o  = 1'b1;
          l2_dat_o = dat_i;
          l2_err_o = bus_err;
          l2_exv_o = exv_q;
          state_d  = (state_q == BUS1) ? SETTLE : BUS1;
        end else begin
          tmo_d = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
        end
      end
      SETTLE: begin
        // tmo counter is zero on entry and reused as the 3-cycle settle count
        if (tmo_q == 8'd2) state_d = L2RD;
        else               tmo_d   = tmo_q + 8'd1;
      end
      L1WR: begin
        l1_wr_o   = ~(inv_q | inv_i);
        l1_wadr_o = ladr_q;
        state_d   = DONE;
      end
      DONE: begin
        l1_wadr_o = ladr_q;
        nxt_o     = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // an aborting reset must not leave a partial write behind
    if (rst) begin
      l2_wr_o = 1'b0;
      l1_wr_o = 1'b0;
      nxt_o   = 1'b0;
    end
  end

  assign l1_dat_o = l1_dat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ladr_q   <= '0;
      exv_q    <= 1'b0;
      inv_q    <= 1'b0;
      tmo_q    <= 8'd0;
      l1_dat_q <= '0;
    end else begin
      state_q  <= state_d;
      ladr_q   <= ladr_d;
      exv_q    <= exv_d;
      inv_q    <= inv_d;
      tmo_q    <= tmo_d;
      l1_dat_q <= l1_dat_d;
    end
  end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl: L2 hit, L2 refill, bus error, timeout,
// invalidate during fill and reset mid-fill.
module tb_icache_fill_ctrl;

  localparam int AMSB = 79;

  logic          clk;
  logic          rst;
  logic          miss_i;
  logic [AMSB:0] miss_adr_i;
  logic          exv_i;
  logic          inv_i;
  logic          busy_o;
  logic [AMSB:0] l2_adr_o;
  logic          l2_wr_o;
  logic [2:0]    l2_cnt_o;
  logic [127:0]  l2_dat_o;
  logic          l2_exv_o;
  logic          l2_err_o;
  logic          l2_hit_i;
  logic [257:0]  l2_dat_i;
  logic          l1_wr_o;
  logic [AMSB:0] l1_wadr_o;
  logic [257:0]  l1_dat_o;
  logic          nxt_o;
  logic          cyc_o;
  logic          stb_o;
  logic [AMSB:0] adr_o;
  logic [127:0]  dat_i;
  logic          ack_i;
  logic          err_i;

  icache_fill_ctrl #(.AMSB(AMSB), .pTimeout(255)) dut (
    .clk(clk), .rst(rst), .miss_i(miss_i), .miss_adr_i(miss_adr_i),
    .exv_i(exv_i), .inv_i(inv_i), .busy_o(busy_o), .l2_adr_o(l2_adr_o),
    .l2_wr_o(l2_wr_o), .l2_cnt_o(l2_cnt_o), .l2_dat_o(l2_dat_o),
    .l2_exv_o(l2_exv_o), .l2_err_o(l2_err_o), .l2_hit_i(l2_hit_i),
    .l2_dat_i(l2_dat_i), .l1_wr_o(l1_wr_o), .l1_wadr_o(l1_wadr_o),
    .l1_dat_o(l1_dat_o), .nxt_o(nxt_o), .cyc_o(cyc_o), .stb_o(stb_o),
    .adr_o(adr_o), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] BA = {16{8'hA5}};
  localparam logic [127:0] BB = {16{8'hB6}};
  localparam logic [257:0] LINE1 = {2'b10, {32{4'h3}}, {32{4'hC}}};

  int n_chk = 0;
  int n_fail = 0;
  int nxt_n = 0, l1wr_n = 0, l2wr_n = 0, cyc_n = 0, ordbad_n = 0;
  int nxt0, l1wr0, l2wr0, cyc0;
  int n;

  always @(negedge clk) begin
    if (nxt_o)   nxt_n  <= nxt_n + 1;
    if (l1_wr_o) l1wr_n <= l1wr_n + 1;
    if (l2_wr_o) l2wr_n <= l2wr_n + 1;
    if (cyc_o)   cyc_n  <= cyc_n + 1;
    if (nxt_o && (l2_wr_o || cyc_o || l1_wr_o)) ordbad_n <= ordbad_n + 1;
  end

  task automatic chk(input string tag, input logic [257:0] obs, input logic [257:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    nxt0 = nxt_n; l1wr0 = l1wr_n; l2wr0 = l2wr_n; cyc0 = cyc_n;
  endtask

  task automatic drain(input int max);
    int k;
    k = 0;
    while (busy_o && k < max) begin
      step(); #1;
      k++;
    end
    chk("drain_idle", 258'(busy_o), 258'(0));
  endtask

  // first three cycles of a fill: accept in IDLE, L2RD, L2CHK
  task automatic start_miss(input logic [AMSB:0] a, input logic e, input logic hit);
    step(); miss_i = 1'b1; miss_adr_i = a; exv_i = e; l2_hit_i = hit; #1;
    step(); miss_i = 1'b0; exv_i = 1'b0; #1;
    step(); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; miss_i = 1'b0; miss_adr_i = '0; exv_i = 1'b0; inv_i = 1'b0;
    l2_hit_i = 1'b0; l2_dat_i = '0; dat_i = '0; ack_i = 1'b0; err_i = 1'b0;
    step(); step(); #1;
    chk("rst_busy",   258'(busy_o),   258'(0));
    chk("rst_cyc",    258'(cyc_o),    258'(0));
    chk("rst_stb",    258'(stb_o),    258'(0));
    chk("rst_l2wr",   258'(l2_wr_o),  258'(0));
    chk("rst_l1wr",   258'(l1_wr_o),  258'(0));
    chk("rst_nxt",    258'(nxt_o),    258'(0));
    chk("rst_l2adr",  258'(l2_adr_o), 258'(0));
    chk("rst_l1dat",  l1_dat_o,       258'(0));

    // L2 hit
    snap();
    step(); rst = 1'b0; miss_i = 1'b1; miss_adr_i = 80'h1234; #1;
    chk("t1_idle_busy", 258'(busy_o), 258'(0));
    step(); miss_i = 1'b0; l2_hit_i = 1'b1; l2_dat_i = LINE1; #1;
    chk("t1_l2rd_busy", 258'(busy_o), 258'(1));
    chk("t1_l2adr", 258'(l2_adr_o), 258'(80'h1220));
    step(); #1;
    chk("t1_chk_l1wr", 258'(l1_wr_o), 258'(0));
    step(); #1;
    chk("t1_l1wr", 258'(l1_wr_o), 258'(1));
    chk("t1_l1wadr", 258'(l1_wadr_o), 258'(80'h1220));
    chk("t1_l1dat", l1_dat_o, LINE1);
    chk("t1_nxt_early", 258'(nxt_o), 258'(0));
    step(); #1;
    chk("t1_done_nxt", 258'(nxt_o), 258'(1));
    chk("t1_done_l1dat", l1_dat_o, LINE1);
    step(); #1;
    chk("t1_idle", 258'(busy_o), 258'(0));
    chk("t1_nxt_cnt", 258'(nxt_n - nxt0), 258'(1));
    chk("t1_cyc_cnt", 258'(cyc_n - cyc0), 258'(0));

    // L2 miss and refill; miss_i held high while busy must be ignored
    snap();
    step(); miss_i = 1'b1; miss_adr_i = 80'h1234; l2_hit_i = 1'b0; #1;
    step(); #1;
    step(); #1;
    chk("t2_chk_cyc", 258'(cyc_o), 258'(0));
    step(); dat_i = BA; ack_i = 1'b1; #1;
    chk("t2_b0_cyc", 258'(cyc_o), 258'(1));
    chk("t2_b0_stb", 258'(stb_o), 258'(1));
    chk("t2_b0_adr", 258'(adr_o), 258'(80'h1220));
    chk("t2_b0_l2wr", 258'(l2_wr_o), 258'(1));
    chk("t2_b0_cnt", 258'(l2_cnt_o), 258'(0));
    chk("t2_b0_dat", 258'(l2_dat_o), 258'(BA));
    chk("t2_b0_err", 258'(l2_err_o), 258'(0));
    step(); dat_i = BB; #1;
    chk("t2_b1_adr", 258'(adr_o), 258'(80'h1230));
    chk("t2_b1_l2adr", 258'(l2_adr_o), 258'(80'h1230));
    chk("t2_b1_cnt", 258'(l2_cnt_o), 258'(1));
    chk("t2_b1_dat", 258'(l2_dat_o), 258'(BB));
    chk("t2_b1_cyc", 258'(cyc_o), 258'(1));
    step(); ack_i = 1'b0; dat_i = '0; l2_hit_i = 1'b1; l2_dat_i = {2'b00, BB, BA}; #1;
    chk("t2_settle_cyc", 258'(cyc_o), 258'(0));
    chk("t2_settle_nxt", 258'(nxt_o), 258'(0));
    chk("t2_settle_l2adr", 258'(l2_adr_o), 258'(80'h1220));
    for (int i = 0; i < 4; i++) begin
      step(); #1;
      chk("t2_wait_l1wr", 258'(l1_wr_o), 258'(0));
    end
    step(); #1;
    chk("t2_l1wr", 258'(l1_wr_o), 258'(1));
    chk("t2_l1dat", l1_dat_o, {2'b00, BB, BA});
    step(); miss_i = 1'b0; #1;
    chk("t2_nxt", 258'(nxt_o), 258'(1));
    step(); #1;
    chk("t2_idle", 258'(busy_o), 258'(0));
    chk("t2_nxt_cnt", 258'(nxt_n - nxt0), 258'(1));
    chk("t2_l1wr_cnt", 258'(l1wr_n - l1wr0), 258'(1));
    chk("t2_l2wr_cnt", 258'(l2wr_n - l2wr0), 258'(2));

    // error on beat 1 with execute violation
    snap();
    start_miss(80'h5678, 1'b1, 1'b0);
    step(); dat_i = BA; ack_i = 1'b1; #1;
    chk("t3_b0_adr", 258'(adr_o), 258'(80'h5660));
    chk("t3_b0_err", 258'(l2_err_o), 258'(0));
    chk("t3_b0_exv", 258'(l2_exv_o), 258'(1));
    step(); ack_i = 1'b0; err_i = 1'b1; dat_i = BB; #1;
    chk("t3_b1_wr", 258'(l2_wr_o), 258'(1));
    chk("t3_b1_err", 258'(l2_err_o), 258'(1));
    chk("t3_b1_exv", 258'(l2_exv_o), 258'(1));
    step(); err_i = 1'b0; l2_hit_i = 1'b1; l2_dat_i = {2'b11, BB, BA};
    drain(20);
    chk("t3_l1dat", l1_dat_o, {2'b11, BB, BA});
    chk("t3_nxt_cnt", 258'(nxt_n - nxt0), 258'(1));
    chk("t3_l1wr_cnt", 258'(l1wr_n - l1wr0), 258'(1));
    chk("t3_l2wr_cnt", 258'(l2wr_n - l2wr0), 258'(2));

    // beat 0 never answered: forced error after the timeout
    snap();
    start_miss(80'h9000_0040, 1'b0, 1'b0);
    step(); #1;
    n = 0;
    while (!l2_wr_o && n < 300) begin
      step(); #1;
      n++;
    end
    chk("t4_tmo_cycles", 258'(n), 258'(255));
    chk("t4_tmo_err", 258'(l2_err_o), 258'(1));
    chk("t4_tmo_cnt", 258'(l2_cnt_o), 258'(0));
    step(); ack_i = 1'b1; dat_i = BA; #1;
    chk("t4_b1_wr", 258'(l2_wr_o), 258'(1));
    chk("t4_b1_cnt", 258'(l2_cnt_o), 258'(1));
    chk("t4_b1_err", 258'(l2_err_o), 258'(0));
    step(); ack_i = 1'b0; l2_hit_i = 1'b1;
    drain(20);
    chk("t4_nxt_cnt", 258'(nxt_n - nxt0), 258'(1));
    chk("t4_l2wr_cnt", 258'(l2wr_n - l2wr0), 258'(2));

    // invalidate during beat 1 suppresses the L1 write only
    snap();
    start_miss(80'h2000, 1'b0, 1'b0);
    step(); ack_i = 1'b1; dat_i = BA; #1;
    step(); dat_i = BB; inv_i = 1'b1; #1;
    chk("t5_b1_wr", 258'(l2_wr_o), 258'(1));
    step(); ack_i = 1'b0; inv_i = 1'b0; l2_hit_i = 1'b1;
    drain(20);
    chk("t5_l1wr_cnt", 258'(l1wr_n - l1wr0), 258'(0));
    chk("t5_nxt_cnt", 258'(nxt_n - nxt0), 258'(1));
    chk("t5_l2wr_cnt", 258'(l2wr_n - l2wr0), 258'(2));

    // reset during beat 0, then a normal hit
    snap();
    start_miss(80'h3000, 1'b0, 1'b0);
    step(); ack_i = 1'b1; dat_i = BA; rst = 1'b1; #1;
    chk("t6_rst_cyc", 258'(cyc_o), 258'(1));
    chk("t6_rst_l2wr", 258'(l2_wr_o), 258'(0));
    step(); rst = 1'b0; ack_i = 1'b0; #1;
    chk("t6_after_cyc", 258'(cyc_o), 258'(0));
    chk("t6_after_stb", 258'(stb_o), 258'(0));
    chk("t6_after_busy", 258'(busy_o), 258'(0));
    chk("t6_l2wr_cnt", 258'(l2wr_n - l2wr0), 258'(0));
    l2_dat_i = LINE1;
    start_miss(80'hABCDE7, 1'b0, 1'b1);
    step(); #1;
    chk("t6_l1wr", 258'(l1_wr_o), 258'(1));
    chk("t6_l1wadr", 258'(l1_wadr_o), 258'(80'hABCDE0));
    drain(20);
    chk("t6_nxt_cnt", 258'(nxt_n - nxt0), 258'(1));
    chk("t6_l1wr_cnt", 258'(l1wr_n - l1wr0), 258'(1));

    step(); #1;
    chk("nxt_ordering", 258'(ordbad_n), 258'(0));

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
